// File: rtl/gppcu_wb_arbiter.sv
// rtl/gppcu_wb_arbiter.sv - GPPCU write-back arbiter: per-source result FIFOs round-robined onto one register-file write port
//
// Ports:
//   iACLK, inRST                                 clock, synchronous active-low reset
//   iALU_VALID / oALU_READY / iALU_REG / iALU_DATA   ALU result push interface
//   iLSU_VALID / oLSU_READY / iLSU_REG / iLSU_DATA   LSU result push interface
//   oWRREG / oWRDATA / oWRREG_VALID              registered register-file and scoreboard-release write port
//   oIDLE                                        both FIFOs empty and no write strobe in flight
module gppcu_wb_arbiter #(
  parameter int NUMREG     = 32,
  parameter int DATAW      = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int RBW       = (NUMREG > 1) ? $clog2(NUMREG) : 1
) (
  input  logic             iACLK,
  input  logic             inRST,
  input  logic             iALU_VALID,
  output logic             oALU_READY,
  input  logic [RBW-1:0]   iALU_REG,
  input  logic [DATAW-1:0] iALU_DATA,
  input  logic             iLSU_VALID,
  output logic             oLSU_READY,
  input  logic [RBW-1:0]   iLSU_REG,
  input  logic [DATAW-1:0] iLSU_DATA,
  output logic [RBW-1:0]   oWRREG,
  output logic [DATAW-1:0] oWRDATA,
  output logic             oWRREG_VALID,
  output logic             oIDLE
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = RBW + DATAW;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Source index 0 is the ALU, 1 is the LSU.
  logic [EW-1:0]    mem_q  [2][FIFO_DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic             rr_q, rr_d;
  logic             wr_valid_q, wr_valid_d;
  logic [RBW-1:0]   wr_reg_q, wr_reg_d;
  logic [DATAW-1:0] wr_data_q, wr_data_d;

  logic [1:0]       in_valid;
  logic [1:0]       ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;
  logic [EW-1:0]    in_entry [2];
  logic             gnt;
  logic             pop_any;
  logic [EW-1:0]    head;

  assign in_valid    = {iLSU_VALID, iALU_VALID};
  assign in_entry[0] = {iALU_REG, iALU_DATA};
  assign in_entry[1] = {iLSU_REG, iLSU_DATA};

  // READY looks only at the registered count, so a full FIFO stays
  // not-ready even in the cycle it is popped.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s]    = inRST && (cnt_q[s] < DEPTH_C);
      nonempty[s] = (cnt_q[s] != '0);
      push[s]     = in_valid[s] && ready[s];
    end
  end

  // Round-robin only matters when both FIFOs hold entries; otherwise the
  // single non-empty source wins (gnt defaults to ALU when nothing pops).
  always_comb begin
    pop_any = nonempty[0] || nonempty[1];
    if (nonempty[0] && nonempty[1]) begin
      gnt = rr_q;
    end else begin
      gnt = nonempty[1];
    end
    pop = '0;
    if (pop_any) begin
      pop[gnt] = 1'b1;
    end
    rr_d = pop_any ? ~gnt : rr_q;
    head = mem_q[gnt][rptr_q[gnt]];
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = push[s] ? wptr_q[s] + 1'b1 : wptr_q[s];
      rptr_d[s] = pop[s]  ? rptr_q[s] + 1'b1 : rptr_q[s];
      cnt_d[s]  = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
    wr_valid_d = pop_any;
    wr_reg_d   = pop_any ? head[EW-1:DATAW] : wr_reg_q;
    wr_data_d  = pop_any ? head[DATAW-1:0]  : wr_data_q;
  end

  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      rr_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      rr_q       <= rr_d;
      wr_valid_q <= wr_valid_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Entry storage needs no reset: counts and pointers gate every read.
  always_ff @(posedge iACLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wptr_q[s]] <= in_entry[s];
      end
    end
  end

  assign oALU_READY   = ready[0];
  assign oLSU_READY   = ready[1];
  assign oWRREG       = wr_reg_q;
  assign oWRDATA      = wr_data_q;
  assign oWRREG_VALID = wr_valid_q;
  assign oIDLE        = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !wr_valid_q;

endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// tb/tb_gppcu_wb_arbiter.sv - self-checking bench for gppcu_wb_arbiter
module tb_gppcu_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_reg, lsu_reg;
  logic [31:0] alu_data, lsu_data;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gppcu_wb_arbiter #(.NUMREG(32), .DATAW(32), .FIFO_DEPTH(4)) dut (
    .iACLK(clk), .inRST(rst_n),
    .iALU_VALID(alu_valid), .oALU_READY(alu_ready), .iALU_REG(alu_reg), .iALU_DATA(alu_data),
    .iLSU_VALID(lsu_valid), .oLSU_READY(lsu_ready), .iLSU_REG(lsu_reg), .iLSU_DATA(lsu_data),
    .oWRREG(wr_reg), .oWRDATA(wr_data), .oWRREG_VALID(wr_valid), .oIDLE(idle)
  );

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  areg;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lreg;
    logic [31:0] ldata;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_wv;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_idle;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic ea, input logic el, input logic ew, input logic [4:0] ereg,
                              input logic [31:0] edat, input logic ei);
    vec_t v;
    v.rst_n = r;   v.av = av;     v.areg = ar;     v.adata = ad;
    v.lv = lv;     v.lreg = lr;   v.ldata = ld;
    v.e_ardy = ea; v.e_lrdy = el; v.e_wv = ew;     v.e_wreg = ereg;
    v.e_wdata = edat; v.e_idle = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    rst_n = r;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    lsu_valid = lv; lsu_reg = lr; lsu_data = ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a_idx, a_seen, l_idx, l_seen, last_src, src, cyc;
    logic l_full;

    // Each row: inputs for this cycle, then outputs expected during it.
    vecs[0]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0,        1);
    vecs[1]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0,        1);
    vecs[2]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0,        1);
    vecs[3]  = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 32'h0,        1);
    vecs[4]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 0, 32'h0,        1);
    vecs[5]  = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 32'h0,        0);
    vecs[6]  = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 5, 32'hDEADBEEF, 0);
    vecs[7]  = mk(1, 0, 0, 0,            1, 7, 32'h12345678, 1, 1, 0, 5, 32'hDEADBEEF, 1);
    vecs[8]  = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 5, 32'hDEADBEEF, 0);
    vecs[9]  = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 7, 32'h12345678, 0);
    vecs[10] = mk(1, 1, 1, 32'h11,       1, 2, 32'h22,       1, 1, 0, 7, 32'h12345678, 1);
    vecs[11] = mk(1, 1, 3, 32'h33,       1, 4, 32'h44,       1, 1, 0, 7, 32'h12345678, 0);
    vecs[12] = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 1, 32'h11,       0);
    vecs[13] = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 2, 32'h22,       0);
    vecs[14] = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 3, 32'h33,       0);
    vecs[15] = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 4, 32'h44,       0);
    vecs[16] = mk(1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 4, 32'h44,       1);

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].av, vecs[i].areg, vecs[i].adata, vecs[i].lv, vecs[i].lreg, vecs[i].ldata);
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ardy);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vecs[i].e_lrdy);
      chk($sformatf("v%0d_wr_valid", i), wr_valid, vecs[i].e_wv);
      chk($sformatf("v%0d_wr_reg", i), wr_reg, vecs[i].e_wreg);
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wdata);
      chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
    end

    // LSU pushes REG 8..15 against a flooded ALU; LSU must fill and back off.
    a_idx = 0; a_seen = 0; l_idx = 0; l_seen = 0; last_src = 1; cyc = 0; l_full = 1'b0;
    while (l_seen < 8 && cyc < 200) begin
      @(negedge clk);
      drive(1, 1, 5'(16 + (a_idx % 16)), 32'hA000_0000 | a_idx,
            (l_idx < 8), 5'(8 + l_idx), 32'hB000_0000 | l_idx);
      #1;
      if (wr_valid) begin
        if (wr_reg >= 5'd16) begin
          src = 0;
          chk("full_alu_reg", wr_reg, 16 + (a_seen % 16));
          chk("full_alu_data", wr_data, 32'hA000_0000 | a_seen);
          a_seen++;
        end else begin
          src = 1;
          chk("full_lsu_reg", wr_reg, 8 + l_seen);
          chk("full_lsu_data", wr_data, 32'hB000_0000 | l_seen);
          l_seen++;
        end
        chk("full_alternate", src, 1 - last_src);
        last_src = src;
      end
      chk("full_lsu_ready", lsu_ready, ((l_idx - l_seen) < 4) ? 1 : 0);
      chk("full_alu_ready", alu_ready, ((a_idx - a_seen) < 4) ? 1 : 0);
      if (!lsu_ready) l_full = 1'b1;
      if (lsu_ready && l_idx < 8) l_idx++;
      if (alu_ready) a_idx++;
      cyc++;
    end
    chk("full_budget", (cyc < 200) ? 1 : 0, 1);
    chk("full_lsu_was_full", l_full, 1);

    cyc = 0;
    do begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      if (wr_valid) begin
        chk("drain_alu_reg", wr_reg, 16 + (a_seen % 16));
        chk("drain_alu_data", wr_data, 32'hA000_0000 | a_seen);
        a_seen++;
      end
      cyc++;
    end while (!idle && cyc < 50);
    chk("drain_idle", idle, 1);
    chk("drain_all_alu_written", a_seen, a_idx);

    // Ten back-to-back LSU entries wrap the 4-deep pointers twice.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, (c < 10), 5'(c), 32'hC000_0000 | c);
      #1;
      if (c < 10) chk("wrap_ready", lsu_ready, 1);
      if (c >= 2 && c <= 11) begin
        chk("wrap_valid", wr_valid, 1);
        chk("wrap_reg", wr_reg, c - 2);
        chk("wrap_data", wr_data, 32'hC000_0000 | (c - 2));
      end else begin
        chk("wrap_quiet", wr_valid, 0);
      end
    end

    // Reset while both FIFOs still hold entries.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 1, 5'(20 + 2 * c), 32'hD000_0000 | c, 1, 5'(21 + 2 * c), 32'hE000_0000 | c);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid_busy_before", idle, 0);
    chk("rstmid_alu_ready_low", alu_ready, 0);
    chk("rstmid_lsu_ready_low", lsu_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rstmid_no_write", wr_valid, 0);
      chk("rstmid_idle", idle, 1);
    end
    chk("rstmid_reg_cleared", wr_reg, 0);
    chk("rstmid_data_cleared", wr_data, 0);
    chk("rstmid_ready_back", alu_ready & lsu_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
